regfile_rr_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one 4x32 register file between four requesters.

---
 rtl/regfile_rr_arbiter_pkg.sv | 15 +
 rtl/regfile_rr_arbiter_pick.sv | 45 ++++
 rtl/regfile_rr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regfile_rr_arbiter_pkg.sv
// Shared definitions for the round-robin register-file arbiter.
// Holds the sequencer state encoding and the default geometry of the 4x32 file.
package regfile_rr_arbiter_pkg;

  localparam int RF_NREQ = 4;
  localparam int RF_DW   = 32;
  localparam int RF_AW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_rr_arbiter_pick.sv
// Combinational helpers for the arbiter.
// rr_pick4 finds the first requester at or after the rotation pointer.
// decoder2_4 is the 2-to-4 one-hot decoder used for grants and write enables.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest hit wins
  always_comb begin
    any = |req;
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) begin
        win = idx;
      end
    end
  end

endmodule

module decoder2_4 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  // Plain binary-to-one-hot decode
  always_comb begin
    onehot = 4'b0000;
    case (sel)
      2'd0: onehot = 4'b0001;
      2'd1: onehot = 4'b0010;
      2'd2: onehot = 4'b0100;
      2'd3: onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  end

endmodule

// File: rtl/regfile_rr_arbiter.sv
// Round-robin sequencer sharing one 4x32 register file between four clients.
// One transaction at a time: IDLE samples requests, SERVE drives the file for
// a single cycle, RESP returns read data. Every output is a register, so the
// file sees clean enables and reset removes a pending write immediately.
module regfile_rr_arbiter
  import regfile_rr_arbiter_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               rvalid,
  output logic [1:0]         rid,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [3:0]         reg_we,
  output logic [DW-1:0]      reg_wdata,
  output logic [AW-1:0]      reg_rsel,
  input  logic [DW-1:0]      reg_rdata
);

  state_t        state;
  logic [1:0]    ptr;
  logic          any;
  logic [1:0]    win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [3:0]    win_onehot;
  logic [3:0]    addr_onehot;
  logic          op_we;
  logic [1:0]    op_id;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  // Route the winning requester's op, address and data toward the serve registers
  always_comb begin
    win_we    = we[win];
    win_addr  = addr[int'(win)*AW +: AW];
    win_wdata = wdata[int'(win)*DW +: DW];
  end

  decoder2_4 u_gnt_dec (
    .sel    (win),
    .onehot (win_onehot)
  );

  decoder2_4 u_we_dec (
    .sel    (win_addr),
    .onehot (addr_onehot)
  );

  // Sequencer: arbitration, operand capture and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      op_we     <= 1'b0;
      op_id     <= 2'd0;
      gnt       <= '0;
      reg_we    <= 4'b0000;
      reg_wdata <= '0;
      reg_rsel  <= '0;
      rvalid    <= 1'b0;
      rid       <= 2'd0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rvalid <= 1'b0;
          if (any) begin
            op_id <= win;
            op_we <= win_we;
            ptr   <= win + 2'd1;
            gnt   <= win_onehot;
            busy  <= 1'b1;
            state <= ST_SERVE;
            if (win_we) begin
              reg_we    <= addr_onehot;
              reg_wdata <= win_wdata;
            end else begin
              reg_rsel  <= win_addr;
            end
          end
        end

        ST_SERVE: begin
          gnt    <= '0;
          reg_we <= 4'b0000;
          if (op_we) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            rdata  <= reg_rdata;
            rvalid <= 1'b1;
            rid    <= op_id;
            state  <= ST_RESP;
          end
        end

        ST_RESP: begin
          rvalid <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          gnt    <= '0;
          reg_we <= 4'b0000;
          rvalid <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
